slc_mem_responder: RTL and testbench
====================================

Name: slc_mem_responder

Overview:
Memory-side responder for the SLC datapath's memory request interface. The CPU side initiates single-word read/write requests. This block accepts them, inserts a programmable number of wait states, and then returns read data with a one-cycle ready strobe. It sits between the SLC core and on-chip block RAM inside the top level, and also exposes the board switches and hex display as a memory-mapped I/O word.

Parameters:
ADDR_W, 10, number of low address bits decoded into on-chip RAM (RAM depth = 2**ADDR_W words of 16 bits)
WAIT_CYCLES, 2, wait states inserted between request acceptance and response (0..15)
IO_ADDR, 16'hFFFF, full 16-bit address of the memory-mapped switch/hex I/O word

Ports:
Clk  input  1  system clock; all state changes on the rising edge
Reset  input  1  asynchronous, active-low reset
mem_req  input  1  request valid from the CPU; level, held until mem_ready is seen
mem_we  input  1  1 = write, 0 = read; sampled with mem_req
mem_addr  input  16  word address; sampled with mem_req
mem_wdata  input  16  write data; sampled with mem_req
S  input  16  board switch value, returned for reads of IO_ADDR
mem_rdata  output  16  read data; valid while mem_ready=1, held until the next response
mem_ready  output  1  single-cycle response strobe
hex_out  output  16  register written by CPU writes to IO_ADDR; drives the hex display
busy  output  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-low on port Reset.
- Reset values: state=IDLE, mem_ready=0, mem_rdata=16'h0000, hex_out=16'h0000, busy=0, wait counter=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP, HOLD.
- IDLE:
  - On a rising edge with mem_req=1, latch mem_we, mem_addr and mem_wdata.
  - Load the counter with WAIT_CYCLES.
  - Go to WAIT, or go directly to RESP if WAIT_CYCLES=0.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to RESP, so WAIT lasts exactly WAIT_CYCLES cycles.
  - Request inputs are ignored in this state; only the latched copy is used.
- RESP (exactly one cycle):
  - mem_ready=1.
  - Read: mem_rdata = RAM[addr[ADDR_W-1:0]], or S when addr==IO_ADDR.
  - Write: RAM (or hex_out when addr==IO_ADDR) is updated on the rising edge that leaves RESP. mem_rdata is unchanged by writes.
  - Next state is HOLD.
- HOLD: remain until mem_req=0 is sampled, then go to IDLE. This prevents a held request from being serviced twice.
- Latency: request sampled at edge k gives mem_ready=1 during the cycle following edge k+WAIT_CYCLES+1, i.e. WAIT_CYCLES+1 cycles after acceptance.
- Address rules:
  - Bits above ADDR_W alias onto RAM; e.g. with ADDR_W=10, address 16'h0400 hits RAM[0].
  - The IO_ADDR compare uses all 16 bits and takes priority over RAM. A write to IO_ADDR never modifies RAM.
- RAM read data must be available in RESP. Implement it as a registered synchronous read issued on the WAIT-to-RESP transition, or as a combinational read; either is acceptable as long as the latency above holds.
- Requester dropping mem_req during WAIT: the transaction still completes and mem_ready still pulses. HOLD then exits on the next cycle.
- Reset asserted mid-operation: the FSM returns immediately to IDLE. A write whose RESP edge has not occurred is discarded. mem_ready drops asynchronously.
- mem_ready is never high for two consecutive cycles.

Optional Feature:
Macro SLC_MEM_PARITY_EN.
- Defined:
  - Each RAM word stores one extra even-parity bit, computed on write.
  - On a read, parity is checked. A mismatch sets a sticky output par_err (1 bit, reset 0). par_err clears only on Reset.
  - The read data is still returned unchanged.
  - The par_err port exists only when the macro is defined.
- Undefined: no parity storage, no par_err port, behaviour otherwise identical.

Test Plan:
- Reset, WAIT_CYCLES=2; write 16'hBEEF to 16'h0005, drop mem_req; read 16'h0005 -> mem_ready pulses exactly 3 cycles after acceptance, mem_rdata=16'hBEEF, held afterwards.
- S=16'h000B; read 16'hFFFF -> mem_rdata=16'h000B. Write 16'h1234 to 16'hFFFF -> hex_out=16'h1234, and a subsequent read of 16'h03FF is unaffected.
- Aliasing: write 16'hA5A5 to 16'h0401, read 16'h0001 -> 16'hA5A5.
- Hold mem_req high for 10 cycles after the response -> exactly one mem_ready pulse and busy stays high. Deassert mem_req -> IDLE the next cycle and busy=0.
- Assert Reset during WAIT of a write of 16'h5555 to 16'h0010 -> mem_ready=0 immediately, and a later read of 16'h0010 returns the prior contents.
- WAIT_CYCLES=0 build: read -> mem_ready 1 cycle after acceptance. With SLC_MEM_PARITY_EN, force a flipped parity bit via hierarchical reference, read -> par_err=1 and it stays set until Reset.

Source files
------------

// File: rtl/slc_mem_responder.sv
// slc_mem_responder: memory-side responder for the SLC CPU request port.
// Accepts single-word read/write requests, inserts WAIT_CYCLES wait states,
// then returns a one-cycle mem_ready strobe with registered read data.
// Address IO_ADDR maps to the board switches (reads) and hex display (writes).
// Optional macro SLC_MEM_PARITY_EN adds an even-parity bit per RAM word and a
// sticky par_err output.
module slc_mem_responder #(
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  input  logic [15:0] S,
  output logic [15:0] mem_rdata,
  output logic        mem_ready,
  output logic [15:0] hex_out,
`ifdef SLC_MEM_PARITY_EN
  output logic        par_err,
`endif
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef SLC_MEM_PARITY_EN
  localparam int WORD_W = 17;
`else
  localparam int WORD_W = 16;
`endif
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic [15:0] hex_q, hex_d;
`ifdef SLC_MEM_PARITY_EN
  logic        par_err_q, par_err_d;
`endif

  logic [WORD_W-1:0] ram_q [DEPTH];
  logic [ADDR_W-1:0] ram_idx;
  logic [WORD_W-1:0] ram_rd;
  logic [WORD_W-1:0] ram_wr_word;
  logic              ram_wr_en;
  logic              is_io;

  // Upper address bits alias onto RAM; the I/O word compares all 16 bits.
  assign ram_idx = addr_q[ADDR_W-1:0];
  assign ram_rd  = ram_q[ram_idx];
  assign is_io   = (addr_q == IO_ADDR);
`ifdef SLC_MEM_PARITY_EN
  assign ram_wr_word = {^wdata_q, wdata_q};
`else
  assign ram_wr_word = wdata_q;
`endif

  // Next-state logic: RESP performs the access; mem_ready and read data are
  // registered on the edge leaving RESP, together with any write.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    hex_d     = hex_q;
    ram_wr_en = 1'b0;
`ifdef SLC_MEM_PARITY_EN
    par_err_d = par_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          we_d    = mem_we;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          cnt_d   = WAIT_LD;
          state_d = (WAIT_LD == 4'd0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        ready_d = 1'b1;
        state_d = ST_HOLD;
        if (we_q) begin
          if (is_io) begin
            hex_d = wdata_q;
          end else begin
            ram_wr_en = 1'b1;
          end
        end else begin
          if (is_io) begin
            rdata_d = S;
          end else begin
            rdata_d = ram_rd[15:0];
`ifdef SLC_MEM_PARITY_EN
            if (^ram_rd) begin
              par_err_d = 1'b1;
            end
`endif
          end
        end
      end
      ST_HOLD: begin
        if (!mem_req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      rdata_q   <= 16'h0000;
      ready_q   <= 1'b0;
      hex_q     <= 16'h0000;
`ifdef SLC_MEM_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      hex_q     <= hex_d;
`ifdef SLC_MEM_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge Clk) begin
    if (ram_wr_en) begin
      ram_q[ram_idx] <= ram_wr_word;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign hex_out   = hex_q;
  assign busy      = (state_q != ST_IDLE);
`ifdef SLC_MEM_PARITY_EN
  assign par_err   = par_err_q;
`endif

endmodule

// File: tb/tb_slc_mem_responder.sv
// tb_slc_mem_responder: directed bench with a scoreboard of expected responses.
// Instance dut uses WAIT_CYCLES=2, instance dut0 uses WAIT_CYCLES=0.
// Honours SLC_MEM_PARITY_EN to exercise the parity error flag.
module tb_slc_mem_responder;

  logic        Clk;
  logic        Reset;
  logic        req2, req0;
  logic        mem_we;
  logic [15:0] mem_addr, mem_wdata, S;
  logic [15:0] rdata2, rdata0, hex2, hex0;
  logic        ready2, ready0, busy2, busy0;
`ifdef SLC_MEM_PARITY_EN
  logic        perr2, perr0;
`endif

  int checks = 0;
  int errors = 0;
  int sel    = 2;

  typedef struct {
    bit          isRead;
    logic [15:0] data;
    int          lat;
  } exp_t;

  exp_t sb[$];

  slc_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2), .IO_ADDR(16'hFFFF)) dut (
    .Clk(Clk), .Reset(Reset), .mem_req(req2), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .S(S),
    .mem_rdata(rdata2), .mem_ready(ready2), .hex_out(hex2),
`ifdef SLC_MEM_PARITY_EN
    .par_err(perr2),
`endif
    .busy(busy2)
  );

  slc_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0), .IO_ADDR(16'hFFFF)) dut0 (
    .Clk(Clk), .Reset(Reset), .mem_req(req0), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .S(S),
    .mem_rdata(rdata0), .mem_ready(ready0), .hex_out(hex0),
`ifdef SLC_MEM_PARITY_EN
    .par_err(perr0),
`endif
    .busy(busy0)
  );

  // Free-running 10-unit clock.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic obsReady();
    return (sel == 0) ? ready0 : ready2;
  endfunction

  function automatic logic obsBusy();
    return (sel == 0) ? busy0 : busy2;
  endfunction

  function automatic logic [15:0] obsRdata();
    return (sel == 0) ? rdata0 : rdata2;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic setReq(input logic v);
    if (sel == 0) req0 = v;
    else          req2 = v;
  endtask

  task automatic applyStimulus(input logic we, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic [15:0] expData);
    exp_t e;
    mem_we    = we;
    mem_addr  = addr;
    mem_wdata = wdata;
    setReq(1'b1);
    e.isRead = !we;
    e.data   = expData;
    e.lat    = (sel == 0) ? 1 : 3;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input int lat);
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("latency", lat, e.lat);
      if (e.isRead) check("rdata", obsRdata(), e.data);
    end
  endtask

  task automatic waitResponse(input bit dropInWait);
    int cycles = 0;
    bit seen = 1'b0;
    while (!seen && cycles < 40) begin
      tick();
      cycles++;
      if (dropInWait && cycles == 1) setReq(1'b0);
      if (obsReady()) seen = 1'b1;
    end
    check("ready_seen", {31'd0, seen}, 32'd1);
    if (seen) checkOutput(cycles - 1);
    else if (sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic endTransaction();
    setReq(1'b0);
    tick();
    check("ready_single", obsReady(), 0);
    check("busy_idle", obsBusy(), 0);
  endtask

  task automatic doWrite(input logic [15:0] addr, input logic [15:0] data);
    applyStimulus(1'b1, addr, data, 16'h0000);
    waitResponse(1'b0);
    endTransaction();
  endtask

  task automatic doRead(input logic [15:0] addr, input logic [15:0] expData);
    applyStimulus(1'b0, addr, 16'h0000, expData);
    waitResponse(1'b0);
    endTransaction();
  endtask

  // Directed sequence of transactions.
  initial begin
    int pulses;
    int busyLow;
    Reset     = 1'b0;
    req2      = 1'b0;
    req0      = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    S         = 16'h0000;
    #2;
    check("rst_ready", ready2, 0);
    check("rst_rdata", rdata2, 16'h0000);
    check("rst_hex", hex2, 16'h0000);
    check("rst_busy", busy2, 0);
    tick();
    tick();
    Reset = 1'b1;

    $display("[TB] basic write/read with 2 wait states");
    doWrite(16'h0005, 16'hBEEF);
    doRead(16'h0005, 16'hBEEF);
    repeat (3) tick();
    check("rdata_held", rdata2, 16'hBEEF);
    check("ready_idle", ready2, 0);

    $display("[TB] memory-mapped I/O");
    S = 16'h000B;
    doRead(16'hFFFF, 16'h000B);
    doWrite(16'h03FF, 16'h7777);
    doWrite(16'hFFFF, 16'h1234);
    check("hex_write", hex2, 16'h1234);
    doRead(16'h03FF, 16'h7777);

    $display("[TB] address aliasing");
    doWrite(16'h0401, 16'hA5A5);
    doRead(16'h0001, 16'hA5A5);

    $display("[TB] request held after response");
    applyStimulus(1'b0, 16'h0001, 16'h0000, 16'hA5A5);
    waitResponse(1'b0);
    pulses  = 0;
    busyLow = 0;
    repeat (10) begin
      tick();
      if (ready2) pulses++;
      if (!busy2) busyLow++;
    end
    check("hold_pulses", pulses, 0);
    check("hold_busy_low", busyLow, 0);
    endTransaction();

    $display("[TB] request dropped during wait");
    applyStimulus(1'b0, 16'h0005, 16'h0000, 16'hBEEF);
    waitResponse(1'b1);
    endTransaction();

    $display("[TB] reset during write wait states");
    doWrite(16'h0010, 16'h1111);
    applyStimulus(1'b1, 16'h0010, 16'h5555, 16'h0000);
    tick();
    tick();
    check("busy_wait", busy2, 1);
    Reset = 1'b0;
    #1;
    check("rstw_ready", ready2, 0);
    check("rstw_busy", busy2, 0);
    check("rstw_hex", hex2, 16'h0000);
    if (sb.size() > 0) void'(sb.pop_front());
    setReq(1'b0);
    tick();
    Reset = 1'b1;
    doRead(16'h0010, 16'h1111);

    $display("[TB] reset during ready strobe");
    applyStimulus(1'b0, 16'h0005, 16'h0000, 16'hBEEF);
    waitResponse(1'b0);
    Reset = 1'b0;
    #1;
    check("ready_async_drop", ready2, 0);
    check("rdata_rst", rdata2, 16'h0000);
    setReq(1'b0);
    tick();
    Reset = 1'b1;

    $display("[TB] zero wait states");
    sel = 0;
    doWrite(16'h0003, 16'h0042);
    doRead(16'h0003, 16'h0042);
    check("w0_hex", hex0, 16'h0000);
    sel = 2;

`ifdef SLC_MEM_PARITY_EN
    $display("[TB] parity error flag");
    doWrite(16'h0007, 16'h1357);
    doRead(16'h0007, 16'h1357);
    check("par_clean", perr2, 0);
    dut.ram_q[7][16] = ~dut.ram_q[7][16];
    doRead(16'h0007, 16'h1357);
    check("par_set", perr2, 1);
    doRead(16'h0005, 16'hBEEF);
    check("par_sticky", perr2, 1);
    check("par_other", perr0, 0);
    Reset = 1'b0;
    #1;
    check("par_rst", perr2, 0);
    tick();
    Reset = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
